// File: rtl/demux_8x32_ctrl.sv
// demux_8x32_ctrl
//   Sequencer for the 8-to-32 byte-packing demux (clk_4f domain). Owns the
//   byte-lane pointer feeding the demux selector, gates byte acceptance with
//   ready/valid, flags completed words, and recovers from misaligned
//   (sof mid-word) or stalled (idle timeout) byte streams.
//
// Ports
//   clk_4f          in   byte-rate clock, posedge
//   reset           in   synchronous active-high reset
//   valid_in        in   source presents a byte
//   sof_in          in   start-of-word marker (qualified by valid_in)
//   in_ready        out  controller can take a byte
//   lane_load       out  byte accepted this cycle (demux valid)
//   selector_clk_4f out  lane for the accepted byte (0 = bits 31:24)
//   word_valid      out  demux output holds a complete word
//   out_ready       in   consumer takes the word this cycle
//   misalign_err    out  1-cycle pulse, partial word dropped on mid-word sof
//   timeout_err     out  1-cycle pulse, partial word dropped after TIMEOUT idles
//   word_count      out  words handed off, wraps modulo 2^CNT_W
module demux_8x32_ctrl #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             sof_in,
    output logic             in_ready,
    output logic             lane_load,
    output logic [1:0]       selector_clk_4f,
    output logic             word_valid,
    input  logic             out_ready,
    output logic             misalign_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] word_count
);

    // Idle counter only has to reach TIMEOUT; keep at least one bit so the
    // declaration stays legal when the timeout is disabled.
    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [1:0]         ptr, ptr_n;
    logic [IDLE_W-1:0]  idle_cnt, idle_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               mis_n, to_n;
    logic               accept;

    assign in_ready        = (state != HOLD) | out_ready;
    assign accept          = valid_in & in_ready;
    assign lane_load       = accept;
    // A marked byte always lands in lane 0, whatever the pointer says.
    assign selector_clk_4f = (sof_in & valid_in) ? 2'd0 : ptr;
    assign word_valid      = (state == HOLD);

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= 2'd0;
            idle_cnt     <= '0;
            word_count   <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            idle_cnt     <= idle_n;
            word_count   <= cnt_n;
            misalign_err <= mis_n;
            timeout_err  <= to_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idle_n  = '0;
        cnt_n   = word_count;
        mis_n   = 1'b0;
        to_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = FILL;
                    ptr_n   = 2'd1;
                end
            end
            FILL: begin
                if (accept) begin
                    if (sof_in) begin
                        // Resync: drop the partial word, this byte is lane 0.
                        mis_n = 1'b1;
                        ptr_n = 2'd1;
                    end else if (ptr == 2'd3) begin
                        state_n = HOLD;
                        ptr_n   = 2'd0;
                    end else begin
                        ptr_n = ptr + 2'd1;
                    end
                end else if (TIMEOUT != 0) begin
                    idle_n = idle_cnt + IDLE_W'(1);
                    if (idle_n == IDLE_LIM) begin
                        state_n = IDLE;
                        ptr_n   = 2'd0;
                        idle_n  = '0;
                        to_n    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    cnt_n = word_count + CNT_W'(1);
                    // Back-to-back: a byte taken during handoff is lane 0 of
                    // the next word, so the pointer resumes at 1.
                    if (accept) begin
                        state_n = FILL;
                        ptr_n   = 2'd1;
                    end else begin
                        state_n = IDLE;
                        ptr_n   = 2'd0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                ptr_n   = 2'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_demux_8x32_ctrl.sv
module tb_demux_8x32_ctrl;

    localparam int TO = 8;
    localparam int CW = 2;

    logic          clk_4f = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0, sof_in = 1'b0, out_ready = 1'b0;
    logic          in_ready, lane_load, word_valid, misalign_err, timeout_err;
    logic [1:0]    selector_clk_4f;
    logic [CW-1:0] word_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: number of bytes held (4 = complete word waiting),
    // idle cycles seen mid-word, pending error pulses, words handed off.
    int m_nb = 0, m_idle = 0, m_cnt = 0;
    bit m_mis = 0, m_to = 0;

    demux_8x32_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .sof_in(sof_in),
        .in_ready(in_ready), .lane_load(lane_load),
        .selector_clk_4f(selector_clk_4f), .word_valid(word_valid),
        .out_ready(out_ready), .misalign_err(misalign_err),
        .timeout_err(timeout_err), .word_count(word_count)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check every output against the model
    // mid-cycle, then advance the model across the edge.
    task automatic cyc(input bit v, input bit s, input bit r, input bit rst = 0);
        bit e_rdy, e_acc;
        int e_sel;
        valid_in = v; sof_in = s; out_ready = r; reset = rst;
        #1;
        e_rdy = (m_nb != 4) || r;
        e_acc = v && e_rdy;
        e_sel = (v && s) ? 0 : (m_nb == 4 ? 0 : m_nb);
        chk("in_ready", int'(in_ready), int'(e_rdy));
        chk("lane_load", int'(lane_load), int'(e_acc));
        chk("selector", int'(selector_clk_4f), e_sel);
        chk("word_valid", int'(word_valid), int'(m_nb == 4));
        chk("misalign_err", int'(misalign_err), int'(m_mis));
        chk("timeout_err", int'(timeout_err), int'(m_to));
        chk("word_count", int'(word_count), m_cnt);
        @(posedge clk_4f);
        m_mis = 0; m_to = 0;
        if (rst) begin
            m_nb = 0; m_idle = 0; m_cnt = 0;
        end else if (m_nb == 4) begin
            if (r) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                m_nb = e_acc ? 1 : 0;
            end
        end else if (e_acc) begin
            m_idle = 0;
            if (m_nb > 0 && s) begin
                m_mis = 1; m_nb = 1;
            end else begin
                m_nb = m_nb + 1;
            end
        end else if (m_nb > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_nb = 0; m_idle = 0; m_to = 1;
            end
        end
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_count", int'(word_count), 0);

        // 1: streaming, sof on bytes 0 and 4, consumer always ready
        for (int i = 0; i < 8; i++) cyc(1, (i % 4) == 0, 1);
        cyc(0, 0, 1);
        chk("t1_count", int'(word_count), 2);
        cyc(0, 0, 1);

        // 2: consumer stalls with a complete word held
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, i == 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        chk("t2_stall_wv", int'(word_valid), 1);
        cyc(1, 1, 1);
        chk("t2_count", int'(word_count), 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        cyc(0, 0, 1);

        // 3: sof mid-word
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
        chk("t3_mis", int'(misalign_err), 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        chk("t3_wv", int'(word_valid), 1);
        cyc(0, 0, 1);

        // 4: idle timeout mid-word
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0); cyc(1, 0, 0);
        for (int i = 0; i < TO; i++) cyc(0, 0, 0);
        chk("t4_to", int'(timeout_err), 1);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("t4_count", int'(word_count), 0);

        // 5: accept on the cycle the idle count would expire
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0); cyc(1, 0, 0);
        for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("t5_no_to", int'(timeout_err), 0);
        cyc(1, 0, 0);

        // 6: counter wrap, then reset mid-word
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(1, (i % 4) == 0, 1);
        cyc(0, 0, 1);
        chk("t6_wrap", int'(word_count), 1);
        cyc(1, 1, 0); cyc(1, 0, 0);
        cyc(0, 0, 0, 1);
        chk("t6_rst_wv", int'(word_valid), 0);
        cyc(1, 0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
